// File: rtl/mem_byte_bridge_if.sv
// Bundle of MEM-stage request/response and 8-bit RAM port signals for mem_byte_bridge.
// The slave modport is the bridge; master is whatever drives requests and models the RAM.
interface mem_byte_bridge_if #(
  parameter int ADDR_W = 17
);
  // Handshake: a request is taken in IDLE when mem_ce_i=1 and mem_sel_i!=0; stall_req_o
  // is the not-ready signal, high from the accept cycle until the cycle before DONE, and
  // the requester must not present a new request while it is high.
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              stall_req_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    input  mem_data_o, stall_req_o, ram_addr_o, ram_wr_o, ram_dout_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    output mem_data_o, stall_req_o, ram_addr_o, ram_wr_o, ram_dout_o
  );
endinterface

// File: rtl/mem_byte_bridge.sv
// Splits a MEM-stage word access into per-lane byte transfers on an 8-bit synchronous RAM,
// stalling the pipeline until the lane-aligned load word is assembled.
module mem_byte_bridge #(
  parameter int ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_byte_bridge_if.slave      bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic              first_q;
  logic [ADDR_W-3:0] base_q;
  logic [3:0]        pend_q;
  logic [31:0]       wdata_q;
  logic [1:0]        prev_lane_q;

  logic              accept;
  logic              issue;
  logic [3:0]        issue_mask;
  logic [1:0]        issue_lane;
  logic [ADDR_W-3:0] src_base;
  logic              src_we;
  logic [31:0]       src_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.mem_addr_i[31:ADDR_W], bus.mem_addr_i[1:0]};
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    accept     = (state_q == IDLE) && bus.mem_ce_i && (bus.mem_sel_i != 4'd0);
    // In IDLE the first lane is issued straight from the request so strobes start next cycle.
    issue_mask = (state_q == IDLE) ? bus.mem_sel_i : pend_q;
    src_base   = (state_q == IDLE) ? bus.mem_addr_i[ADDR_W-1:2] : base_q;
    src_we     = (state_q == IDLE) ? bus.mem_we_i : we_q;
    src_data   = (state_q == IDLE) ? bus.mem_data_i : wdata_q;
    issue      = accept || ((state_q == XFER) && (pend_q != 4'd0));

    if (issue_mask[0])      issue_lane = 2'd0;
    else if (issue_mask[1]) issue_lane = 2'd1;
    else if (issue_mask[2]) issue_lane = 2'd2;
    else                    issue_lane = 2'd3;

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = XFER;
      XFER:    if (pend_q == 4'd0) state_d = we_q ? DONE : DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bus.stall_req_o = rst && (accept || (state_q == XFER) || (state_q == DRAIN));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q            <= 1'b0;
      first_q         <= 1'b0;
      base_q          <= '0;
      pend_q          <= 4'd0;
      wdata_q         <= 32'd0;
      prev_lane_q     <= 2'd0;
      bus.ram_addr_o  <= '0;
      bus.ram_wr_o    <= 1'b0;
      bus.ram_dout_o  <= 8'd0;
      bus.mem_data_o  <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= bus.mem_we_i;
        base_q  <= bus.mem_addr_i[ADDR_W-1:2];
        wdata_q <= bus.mem_data_i;
        first_q <= 1'b1;
        if (!bus.mem_we_i) bus.mem_data_o <= 32'd0;
      end

      if (issue) begin
        bus.ram_addr_o <= {src_base, issue_lane};
        bus.ram_wr_o   <= src_we;
        if (src_we) bus.ram_dout_o <= src_data[{issue_lane, 3'b000} +: 8];
        pend_q         <= issue_mask & ~(4'b0001 << issue_lane);
      end else begin
        bus.ram_wr_o   <= 1'b0;
      end

      // Read data lags its address by one cycle, so each capture targets the previous lane.
      if ((state_q == XFER) && !we_q) begin
        if (!first_q) bus.mem_data_o[{prev_lane_q, 3'b000} +: 8] <= bus.ram_din_i;
        prev_lane_q <= bus.ram_addr_o[1:0];
        first_q     <= 1'b0;
      end

      if (state_q == DRAIN) bus.mem_data_o[{prev_lane_q, 3'b000} +: 8] <= bus.ram_din_i;
    end
  end

endmodule
